reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the write port of a bank of NREGS load-enabled WIDTH-bit registers among NREQ requesters.
- Each cycle it picks one requester round-robin and drives a one-hot load vector plus a data bus into the bank.
- It sits between the datapath sequencers (requesters) and the register bank; the bank stays a plain load/reset register array.

Parameters:
- WIDTH, 16, data width of each bank register.
- NREQ, 4, number of requesters (2..8).
- NREGS, 8, number of registers in the bank (2..16).
- AW, 3, address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request, level, held until granted.
- req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW].
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot, one-cycle grant pulse (registered).
- load  output  NREGS  one-hot bank load strobe (registered); all-zero when idle.
- d  output  WIDTH  data to bank, valid when load != 0 (registered).
- err  output  1  one-cycle pulse: granted address >= NREGS.
- last_gnt  output  $clog2(NREQ)  index of the most recent grant (registered).

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and reset.
- Reset values: gnt=0, load=0, d=0, err=0, last_gnt=NREQ-1, so requester 0 has top priority after reset.
- Arbitration (combinational, cycle N):
  - eligible = req & ~gnt. The requester granted in the previous cycle is masked for one cycle, which prevents a double grant while it drops req.
  - Search starts at (last_gnt+1) mod NREQ and wraps; the first eligible index wins.
- Outputs (registered at the edge ending cycle N, visible in cycle N+1):
  - gnt[w]=1, last_gnt=w, d=req_data[w].
  - load[req_addr[w]]=1 if req_addr[w] < NREGS; otherwise load=0 and err=1.
  - The bank captures d at the edge ending cycle N+1. Request-to-bank-update latency is 2 edges.
- No eligible requester: gnt=0, load=0, err=0, last_gnt held, d held (don't-care).
- Requester contract: hold req, req_addr and req_data stable until gnt seen; drop req (or present a new request) in the cycle after gnt.
- Throughput:
  - 1 write/cycle when at least 2 requesters are active.
  - 1 write per 2 cycles for a single persistent requester, because of the mask.
- Two requesters targeting the same address in consecutive grants: both writes occur in grant order; the last one wins.
- Reset asserted mid-operation: a pending grant or load registered in that cycle is cancelled (outputs forced to reset values at that edge). Requesters must re-request.
- Width rules:
  - last_gnt increments mod NREQ. For non-power-of-2 NREQ, the wrap uses compare-to-NREQ-1, not bit truncation.
  - req_addr is compared against NREGS at full AW width.

Decomposition:
- Shared package holds:
  - RR_IDX_W = $clog2(NREQ);
  - a function onehot(idx, n);
  - a function rr_pick(eligible, start) returning the winner index and a valid flag.
- One natural sub-module: rr_priority_picker. It is combinational, takes eligible and start, and returns winner and valid. Instantiate it once.
- Output registers and the address decode stay in reg_write_arbiter.

Test Plan:
- After reset, hold req=4'b0001, addr0=3, data0=16'hABCD → cycle+1: gnt=0001, load=8'h08, d=ABCD; next grant 2 cycles later while req is held.
- req=4'b1111 held continuously, distinct addrs 0..3 → gnt sequence 0001,0010,0100,1000,0001; load one-hot tracks each address; one grant per cycle.
- req0 and req2 held, last_gnt=0 → gnt alternates 0100, 0001, 0100; neither requester is starved.
- NREGS=6, requester 1 addr=7 → gnt=0010, load=0, err=1 for exactly one cycle; a bank readback shows no register changed.
- reset asserted in the same cycle req=0010 is sampled → next cycle gnt=0, load=0, last_gnt=NREQ-1; a re-request after reset is granted normally.
- Requesters 0 and 3 write 16'h1111 then 16'h2222 to addr 5 in consecutive grants → bank reg 5 reads 16'h2222 after the second load.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package reg_write_arbiter_pkg;

   // Helper functions are sized for the largest legal configuration.
   // Callers zero-extend their narrower vectors before calling them.
   localparam int MAX_REQ    = 8;
   localparam int MAX_IDX_W  = 3;
   localparam int MAX_ONEHOT = 16;
   localparam int NREQ_DEF   = 4;
   localparam int RR_IDX_W   = $clog2(NREQ_DEF);

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] idx;
   } rr_pick_t;

   // One-hot of idx over an n-bit field; all-zero when idx >= n.
   function automatic logic [MAX_ONEHOT-1:0] onehot(input logic [3:0] idx, input int n);
      logic [MAX_ONEHOT-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_ONEHOT; i++)
         if (i < n && idx == 4'(i)) v[i] = 1'b1;
      return v;
   endfunction

   // First set bit of elig[n-1:0], searching upward from start and wrapping
   // at n. The wrap compares against n-1 so non-power-of-2 n works.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   elig,
                                        input logic [MAX_IDX_W-1:0] start,
                                        input int                   n);
      rr_pick_t             p;
      logic [MAX_IDX_W-1:0] idx;
      logic [MAX_IDX_W-1:0] top;
      p   = '0;
      idx = start;
      top = MAX_IDX_W'(n - 1);
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n && !p.valid && elig[idx]) begin
            p.valid = 1'b1;
            p.idx   = idx;
         end
         idx = (idx == top) ? '0 : idx + 1'b1;
      end
      return p;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_picker.sv
// Combinational round-robin priority picker: first eligible index at or after start.
module rr_priority_picker
   import reg_write_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  eligible_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             valid_o
);

   rr_pick_t pick;

   // Wrap-around search delegated to the shared package function.
   always_comb begin
      pick     = rr_pick(MAX_REQ'(eligible_i), MAX_IDX_W'(start_i), NREQ);
      winner_o = IDX_W'(pick.idx);
      valid_o  = pick.valid;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ requesters.
// All outputs are registered; a grant in cycle N loads the bank at the end of N+1.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREQ  = NREQ_DEF,
   parameter int NREGS = 8,
   parameter int AW    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*AW-1:0]        req_addr,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]           gnt,
   output logic [NREGS-1:0]          load,
   output logic [WIDTH-1:0]          d,
   output logic                      err,
   output logic [$clog2(NREQ)-1:0]   last_gnt
);

   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0]  gnt_q,  gnt_d;
   logic [NREGS-1:0] load_q, load_d;
   logic [WIDTH-1:0] d_q,    d_d;
   logic             err_q,  err_d;
   logic [IDX_W-1:0] last_q, last_d;

   logic [NREQ-1:0]  eligible;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] winner;
   logic             win_vld;
   logic [AW-1:0]    w_addr;
   logic             addr_ok;

   // Mask last cycle's grantee so it cannot win again while dropping req.
   always_comb begin
      eligible = req & ~gnt_q;
      start    = (last_q == IDX_W'(NREQ - 1)) ? '0 : last_q + 1'b1;
   end

   rr_priority_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .eligible_i (eligible),
      .start_i    (start),
      .winner_o   (winner),
      .valid_o    (win_vld)
   );

   // Winner mux, address range check and one-hot decode into next-state values.
   always_comb begin
      w_addr  = req_addr[int'(winner)*AW +: AW];
      addr_ok = 32'(w_addr) < 32'(NREGS);
      gnt_d   = '0;
      load_d  = '0;
      err_d   = 1'b0;
      d_d     = d_q;
      last_d  = last_q;
      if (win_vld) begin
         gnt_d  = NREQ'(onehot(4'(winner), NREQ));
         last_d = winner;
         d_d    = req_data[int'(winner)*WIDTH +: WIDTH];
         err_d  = !addr_ok;
         for (int r = 0; r < NREGS; r++)
            load_d[r] = addr_ok && (32'(w_addr) == 32'(r));
      end
   end

   // Output registers; reset cancels anything that would be registered this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q  <= '0;
         load_q <= '0;
         d_q    <= '0;
         err_q  <= 1'b0;
         last_q <= IDX_W'(NREQ - 1);
      end else begin
         gnt_q  <= gnt_d;
         load_q <= load_d;
         d_q    <= d_d;
         err_q  <= err_d;
         last_q <= last_d;
      end
   end

   assign gnt      = gnt_q;
   assign load     = load_q;
   assign d        = d_q;
   assign err      = err_q;
   assign last_gnt = last_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then random traffic, all
// compared cycle by cycle against a round-robin reference model and a bank model.
module tb_reg_write_arbiter;

   localparam int WIDTH = 16;
   localparam int NREQ  = 4;
   localparam int NREGS = 6;
   localparam int AW    = 3;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*AW-1:0]    req_addr = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       gnt;
   logic [NREGS-1:0]      load;
   logic [WIDTH-1:0]      d;
   logic                  err;
   logic [1:0]            last_gnt;

   reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .gnt(gnt), .load(load), .d(d), .err(err), .last_gnt(last_gnt)
   );

   always #5 clk = ~clk;

   // Plain load/reset register bank driven by the arbiter.
   logic [WIDTH-1:0] bank [NREGS];
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREGS; r++)
         if (reset) bank[r] <= '0;
         else if (load[r]) bank[r] <= d;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Requester state
   bit               rq [NREQ];
   logic [AW-1:0]    ra [NREQ];
   logic [WIDTH-1:0] rd [NREQ];

   // Reference model state
   int               m_last = NREQ - 1;
   int               m_prev = -1;   // index granted last cycle, -1 if none
   int               m_cur  = -1;   // bank address being loaded this cycle, -1 if none
   int               m_w    = -1;   // winner predicted by the latest step
   logic [WIDTH-1:0] m_d    = '0;
   logic             m_err  = 1'b0;
   logic [WIDTH-1:0] mbank [NREGS];

   task automatic set_rq(input int i, input bit on, input int a, input logic [WIDTH-1:0] v);
      rq[i] = on;
      ra[i] = AW'(a);
      rd[i] = v;
   endtask

   task automatic step(input logic rst);
      int w, i;
      logic [NREQ-1:0]  e_gnt;
      logic [NREGS-1:0] e_load;
      reset = rst;
      for (int k = 0; k < NREQ; k++) begin
         req[k] = rq[k];
         req_addr[k*AW +: AW] = ra[k];
         req_data[k*WIDTH +: WIDTH] = rd[k];
      end
      // bank captures whatever write is visible during this cycle
      if (rst) for (int r = 0; r < NREGS; r++) mbank[r] = '0;
      else if (m_cur >= 0) mbank[m_cur] = m_d;
      // round-robin: first requester after the last grantee, skipping last cycle's grantee
      w = -1;
      if (!rst)
         for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (w < 0 && rq[i] && i != m_prev) w = i;
         end
      if (rst) begin
         m_last = NREQ - 1; m_prev = -1; m_cur = -1; m_d = '0; m_err = 1'b0;
      end else if (w >= 0) begin
         m_prev = w; m_last = w; m_d = rd[w];
         if (int'(ra[w]) < NREGS) begin m_cur = int'(ra[w]); m_err = 1'b0; end
         else begin m_cur = -1; m_err = 1'b1; end
      end else begin
         m_prev = -1; m_cur = -1; m_err = 1'b0;
      end
      m_w    = w;
      e_gnt  = (w >= 0) ? NREQ'(1 << w) : '0;
      e_load = (m_cur >= 0) ? NREGS'(1 << m_cur) : '0;
      @(posedge clk); #1;
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("load", 32'(load), 32'(e_load));
      check("d", 32'(d), 32'(m_d));
      check("err", 32'(err), 32'(m_err));
      check("last_gnt", 32'(last_gnt), 32'(m_last));
      for (int r = 0; r < NREGS; r++) check("bank", 32'(bank[r]), 32'(mbank[r]));
   endtask

   task automatic drop_all();
      for (int k = 0; k < NREQ; k++) rq[k] = 1'b0;
   endtask

   logic [NREQ-1:0] rr_seq [5];

   initial begin
      for (int k = 0; k < NREQ; k++) set_rq(k, 1'b0, 0, '0);
      for (int r = 0; r < NREGS; r++) mbank[r] = '0;

      // reset state
      step(1'b1);
      step(1'b1);
      check("rst_last_gnt", 32'(last_gnt), 32'(NREQ - 1));

      // single persistent requester: grant, masked cycle, grant again
      set_rq(0, 1'b1, 3, 16'hABCD);
      step(1'b0);
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_load", 32'(load), 32'h08);
      check("single_d", 32'(d), 32'hABCD);
      step(1'b0);
      check("single_masked", 32'(gnt), 32'h0);
      step(1'b0);
      check("single_regrant", 32'(gnt), 32'h1);
      drop_all();
      step(1'b0);

      // all four held: one grant per cycle in rotation
      step(1'b1);
      for (int k = 0; k < NREQ; k++) set_rq(k, 1'b1, k, WIDTH'(16'h100 + k));
      rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
      rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
      for (int s = 0; s < 5; s++) begin
         step(1'b0);
         check("rr_all_gnt", 32'(gnt), 32'(rr_seq[s]));
      end

      // requesters 0 and 2 alternate starting after last_gnt=0
      rq[1] = 1'b0; rq[3] = 1'b0;
      step(1'b0); check("alt_gnt0", 32'(gnt), 32'h4);
      step(1'b0); check("alt_gnt1", 32'(gnt), 32'h1);
      step(1'b0); check("alt_gnt2", 32'(gnt), 32'h4);
      drop_all();
      step(1'b0);

      // out-of-range address: error pulse, no load
      set_rq(1, 1'b1, 7, 16'hDEAD);
      step(1'b0);
      check("oor_gnt", 32'(gnt), 32'h2);
      check("oor_load", 32'(load), 32'h0);
      check("oor_err", 32'(err), 32'h1);
      drop_all();
      step(1'b0);
      check("oor_err_pulse", 32'(err), 32'h0);

      // reset coincides with a request: cancelled, then granted normally
      set_rq(1, 1'b1, 2, 16'h5A5A);
      step(1'b1);
      check("rst_cancel_gnt", 32'(gnt), 32'h0);
      check("rst_cancel_last", 32'(last_gnt), 32'(NREQ - 1));
      step(1'b0);
      check("rst_regrant", 32'(gnt), 32'h2);
      drop_all();
      step(1'b0);

      // same-address writes in consecutive grants: last one wins
      step(1'b1);
      set_rq(0, 1'b1, 5, 16'h1111);
      set_rq(3, 1'b1, 5, 16'h2222);
      step(1'b0);
      rq[0] = 1'b0;
      step(1'b0);
      rq[3] = 1'b0;
      step(1'b0);
      check("same_addr_bank5", 32'(bank[5]), 32'h2222);

      // random traffic obeying the requester contract
      for (int s = 0; s < 400; s++) begin
         logic rst;
         rst = ($urandom_range(0, 59) == 0);
         step(rst);
         for (int k = 0; k < NREQ; k++) begin
            if (rst) rq[k] = 1'b0;
            else if (k == m_w) begin
               if ($urandom_range(0, 1) == 0) rq[k] = 1'b0;
               else set_rq(k, 1'b1, $urandom_range(0, 7), WIDTH'($urandom));
            end else if (!rq[k] && $urandom_range(0, 9) < 4)
               set_rq(k, 1'b1, $urandom_range(0, 7), WIDTH'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
